// File: rtl/clint_trap_ctrl.sv
// Machine-mode trap sequencer: ecall/ebreak/irq entry and mret return.
// Optional vectored interrupt targets with `define CLINT_VECTORED_EN.
module clint_trap_ctrl #(
  parameter logic [31:0] CAUSE_ECALL  = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK = 32'd3,
  parameter logic [31:0] CAUSE_IRQ    = 32'h8000000B
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  input  logic        irq,
  input  logic [31:0] instAddr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [31:0] mstatus,
  output logic        clintWriteEn,
  output logic [11:0] clintAddr,
  output logic [31:0] clintWriteData,
  output logic        holdReq,
  output logic        jumpEn,
  output logic [31:0] jumpAddr
);

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    W_MRET,
    JUMP
  } state_t;

  state_t      state;
  logic [31:0] epc;
  logic [31:0] cause;
  logic        ret;

  logic        irq_ok;
  logic        any_ev;
  logic [31:0] trap_base;
  logic [31:0] trap_target;
  logic [31:0] st_trap;
  logic [31:0] st_mret;

  assign irq_ok    = irq & mstatus[3];
  assign any_ev    = mret | ecall | ebreak | irq_ok;
  assign trap_base = {mtvec[31:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  logic unused_vec;
  assign unused_vec = cause[30];
  // Only interrupts are vectored; exceptions always land on the base.
  assign trap_target =
    (mtvec[1:0] == 2'b01 && cause[31])
    ? trap_base + {cause[29:0], 2'b00}
    : trap_base;
`else
  logic unused_vec;
  assign unused_vec  = ^mtvec[1:0];
  assign trap_target = trap_base;
`endif

  assign st_trap = {mstatus[31:8], mstatus[3],
                    mstatus[6:4], 1'b0, mstatus[2:0]};
  assign st_mret = {mstatus[31:8], 1'b1,
                    mstatus[6:4], mstatus[7], mstatus[2:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      epc   <= '0;
      cause <= '0;
      ret   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_ev)
            epc <= instAddr;
          priority case (1'b1)
            mret: state <= W_MRET;
            ecall: begin
              cause <= CAUSE_ECALL;
              state <= W_MEPC;
            end
            ebreak: begin
              cause <= CAUSE_EBREAK;
              state <= W_MEPC;
            end
            irq_ok: begin
              cause <= CAUSE_IRQ;
              state <= W_MEPC;
            end
            default: state <= IDLE;
          endcase
        end
        W_MEPC:   state <= W_MCAUSE;
        W_MCAUSE: state <= W_MSTATUS;
        W_MSTATUS: begin
          ret   <= 1'b0;
          state <= JUMP;
        end
        W_MRET: begin
          ret   <= 1'b1;
          state <= JUMP;
        end
        JUMP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    clintWriteEn   = 1'b0;
    clintAddr      = '0;
    clintWriteData = '0;
    holdReq        = 1'b0;
    jumpEn         = 1'b0;
    jumpAddr       = '0;
    unique case (state)
      IDLE: holdReq = rstn & any_ev;
      W_MEPC: begin
        holdReq        = 1'b1;
        clintWriteEn   = 1'b1;
        clintAddr      = 12'h341;
        clintWriteData = epc;
      end
      W_MCAUSE: begin
        holdReq        = 1'b1;
        clintWriteEn   = 1'b1;
        clintAddr      = 12'h342;
        clintWriteData = cause;
      end
      W_MSTATUS: begin
        holdReq        = 1'b1;
        clintWriteEn   = 1'b1;
        clintAddr      = 12'h300;
        clintWriteData = st_trap;
      end
      W_MRET: begin
        holdReq        = 1'b1;
        clintWriteEn   = 1'b1;
        clintAddr      = 12'h300;
        clintWriteData = st_mret;
      end
      JUMP: begin
        holdReq  = 1'b1;
        jumpEn   = 1'b1;
        jumpAddr = ret ? mepc : trap_target;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Bench for clint_trap_ctrl: vector table expanded into a per-cycle
// scoreboard, plus hand sequences for pending irq and mid-sequence reset.
module tb_clint_trap_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ecall = 1'b0;
  logic        ebreak = 1'b0;
  logic        mret = 1'b0;
  logic        irq = 1'b0;
  logic [31:0] instAddr = '0;
  logic [31:0] mtvec = '0;
  logic [31:0] mepc = '0;
  logic [31:0] mstatus = '0;
  logic        clintWriteEn;
  logic [11:0] clintAddr;
  logic [31:0] clintWriteData;
  logic        holdReq;
  logic        jumpEn;
  logic [31:0] jumpAddr;

  clint_trap_ctrl dut (
    .clk(clk),
    .rstn(rstn),
    .ecall(ecall),
    .ebreak(ebreak),
    .mret(mret),
    .irq(irq),
    .instAddr(instAddr),
    .mtvec(mtvec),
    .mepc(mepc),
    .mstatus(mstatus),
    .clintWriteEn(clintWriteEn),
    .clintAddr(clintAddr),
    .clintWriteData(clintWriteData),
    .holdReq(holdReq),
    .jumpEn(jumpEn),
    .jumpAddr(jumpAddr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hold;
    logic        we;
    logic [11:0] a;
    logic [31:0] d;
    logic        je;
    logic [31:0] ja;
  } exp_t;

  typedef struct {
    logic        ec, eb, mr, iq;
    logic [31:0] st, pc, tv, ep;
    int          kind;
    logic [31:0] xcause, xst, xj;
  } vec_t;

`ifdef CLINT_VECTORED_EN
  localparam logic [31:0] IRQ_J = 32'h22C;
`else
  localparam logic [31:0] IRQ_J = 32'h200;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t got;
  exp_t ec_cur;
  vec_t vt[9];

  always_comb got = {holdReq, clintWriteEn, clintAddr,
                     clintWriteData, jumpEn, jumpAddr};

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      ec_cur = sb.pop_front();
      checks++;
      if (got !== ec_cur) begin
        failures++;
        $display("FAIL cyc t=%0t got h%b w%b a%h d%h j%b ja%h want h%b w%b a%h d%h j%b ja%h",
          $time, got.hold, got.we, got.a, got.d, got.je, got.ja,
          ec_cur.hold, ec_cur.we, ec_cur.a, ec_cur.d, ec_cur.je,
          ec_cur.ja);
      end
    end
  end

  function automatic exp_t mk(logic h, logic w, logic [11:0] a,
                              logic [31:0] d, logic j,
                              logic [31:0] ja);
    return {h, w, a, d, j, ja};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) sb.push_back(mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic push_trap(logic [31:0] pc, logic [31:0] c,
                           logic [31:0] st, logic [31:0] j);
    sb.push_back(mk(1, 0, 12'h000, 0, 0, 0));
    sb.push_back(mk(1, 1, 12'h341, pc, 0, 0));
    sb.push_back(mk(1, 1, 12'h342, c, 0, 0));
    sb.push_back(mk(1, 1, 12'h300, st, 0, 0));
    sb.push_back(mk(1, 0, 12'h000, 0, 1, j));
  endtask

  task automatic push_mret(logic [31:0] st, logic [31:0] j);
    sb.push_back(mk(1, 0, 12'h000, 0, 0, 0));
    sb.push_back(mk(1, 1, 12'h300, st, 0, 0));
    sb.push_back(mk(1, 0, 12'h000, 0, 1, j));
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_%s left=%0d want 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic apply(vec_t v);
    step();
    ecall = v.ec; ebreak = v.eb; mret = v.mr; irq = v.iq;
    mstatus = v.st; instAddr = v.pc; mtvec = v.tv; mepc = v.ep;
    case (v.kind)
      1: push_trap(v.pc, v.xcause, v.xst, v.xj);
      2: push_mret(v.xst, v.xj);
      default: ;
    endcase
    if (v.kind == 0) push_idle(1);
    push_idle(1);
    step();
    ecall = 0; ebreak = 0; mret = 0; irq = 0;
    drain("vec");
  endtask

  task automatic chk_zero(string tag);
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL %s got %h want 0", tag, got);
    end
  endtask

  initial begin
    //      ec eb mr iq  mstatus       pc         mtvec      mepc   kind cause       st          jump
    vt[0] = '{1,0,0,0, 32'h8,        32'h100, 32'h200,  32'h0,   1, 32'd11,       32'h80,       32'h200};
    vt[1] = '{0,1,0,0, 32'h88,       32'h2A0, 32'h403,  32'h0,   1, 32'd3,        32'h80,       32'h400};
    vt[2] = '{0,0,0,1, 32'h0,        32'h300, 32'h200,  32'h0,   0, 32'h0,        32'h0,        32'h0};
    vt[3] = '{0,0,0,1, 32'h8,        32'h300, 32'h201,  32'h0,   1, 32'h8000000B, 32'h80,       IRQ_J};
    vt[4] = '{0,0,1,0, 32'h80,       32'h350, 32'h200,  32'h104, 2, 32'h0,        32'h88,       32'h104};
    vt[5] = '{1,0,1,0, 32'h0,        32'h360, 32'h200,  32'h500, 2, 32'h0,        32'h80,       32'h500};
    vt[6] = '{1,1,0,1, 32'hFFFFFFFF, 32'h444, 32'h1000, 32'h0,   1, 32'd11,       32'hFFFFFFF7, 32'h1000};
    vt[7] = '{0,1,0,0, 32'h80,       32'h554, 32'h600,  32'h0,   1, 32'd3,        32'h0,        32'h600};
    vt[8] = '{1,0,0,0, 32'h8,        32'h660, 32'h201,  32'h0,   1, 32'd11,       32'h80,       32'h200};

    #3;
    chk_zero("reset_state");
    step();
    rstn = 1'b1;
    push_idle(2);
    drain("post_reset");

    for (int k = 0; k < 9; k++) apply(vt[k]);

    // ecall and irq together: ecall wins, irq waits for MIE
    step();
    ecall = 1; irq = 1; mstatus = 32'h8;
    instAddr = 32'h700; mtvec = 32'h200; mepc = 32'h0;
    push_trap(32'h700, 32'd11, 32'h80, 32'h200);
    step(); ecall = 0;
    step();
    step();
    step(); mstatus = 32'h80;
    push_idle(3);
    drain("masked");
    step();
    mret = 1; mepc = 32'h700;
    push_mret(32'h88, 32'h700);
    push_trap(32'h700, 32'h8000000B, 32'h80, 32'h200);
    step(); mret = 0;
    step(); mstatus = 32'h88;
    step();
    step(); irq = 0;
    push_idle(1);
    drain("irq_after_mret");

    // reset asserted while writing mcause
    step();
    ecall = 1; mstatus = 32'h8; instAddr = 32'h800; mtvec = 32'h200;
    sb.push_back(mk(1, 0, 12'h000, 0, 0, 0));
    sb.push_back(mk(1, 1, 12'h341, 32'h800, 0, 0));
    step(); ecall = 0;
    step();
    #1 rstn = 1'b0;
    #1 chk_zero("reset_mid_seq");
    step();
    chk_zero("reset_held");
    rstn = 1'b1;
    push_idle(4);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
